if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipeline, and the producer side of the IF/ID pipeline register.
- Holds the PC and a loadable instruction memory, and applies branch/jump redirects.
- Each RUN cycle it drives IF_next_pc and IF_inst into IF/ID, plus a flush request.
- The debug unit loads the program in IDLE and starts execution; a HALT instruction stops fetch.

Parameters:
- MSB, 32, datapath width (PC and instruction).
- IMEM_ADDR, 8, instruction-memory word-address width (depth = 2**IMEM_ADDR words).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset.
- i_enable  in  1  global step/run enable from the debug unit; low freezes all state.
- i_start  in  1  IDLE->RUN request.
- i_stall  in  1  hazard-unit stall; holds the PC.
- i_branch_taken  in  1  branch resolved taken in ID.
- i_branch_target  in  MSB  branch destination byte address.
- i_jump  in  1  jump decoded in ID.
- i_jump_target  in  MSB  jump destination byte address.
- i_load_we  in  1  program-load write strobe.
- i_load_addr  in  IMEM_ADDR  program-load word address.
- i_load_data  in  MSB  program-load word.
- IF_next_pc  out  MSB  PC+4 of the fetched instruction (to IF/ID).
- IF_inst  out  MSB  fetched instruction (to IF/ID).
- o_flush  out  1  flush request to IF/ID (redirect accepted).
- o_pc  out  MSB  current PC (debug readout).
- o_halt  out  1  high while in HALTED.

Behaviour:
- Reset: single clock domain; reset is asynchronous, active-low (i_rst=0 resets).
  - PC=0, state=IDLE.
  - All outputs 0: IF_next_pc=0, IF_inst=0, o_flush=0, o_pc=0, o_halt=0.
  - Memory contents are not cleared.
  - Reset mid-RUN returns to IDLE with PC=0 at once (asynchronously).
- States: IDLE, RUN, HALTED.
  - IDLE->RUN on i_start & i_enable.
  - RUN->HALTED on an accepted HALT fetch.
  - HALTED exits only via reset.
- Instruction memory:
  - Combinational read at word index PC[IMEM_ADDR+1:2].
  - PC[1:0] ignored; addresses beyond the depth wrap modulo depth.
  - Synchronous write of i_load_data at i_load_addr on i_load_we, honoured only in IDLE (enable not required).
  - Writes in RUN or HALTED are ignored.
- Outputs by state:
  - IDLE and HALTED: IF_inst=NOP (0), IF_next_pc=0, o_flush=0.
  - RUN: IF_inst=imem[PC], IF_next_pc=PC+4 (modulo 2**MSB).
  - o_pc=PC always.
  - o_halt = (state==HALTED).
- RUN PC update on a rising edge with i_enable=1, priority order:
  1. i_stall=1: PC holds; redirects are ignored (the stalled ID instruction re-presents them); o_flush=0.
  2. i_branch_taken=1: PC<=i_branch_target; o_flush=1 (combinational, same cycle).
  3. i_jump=1: PC<=i_jump_target; o_flush=1.
  4. IF_inst==HALT_OP: PC holds; state<=HALTED. The HALT word itself is presented that cycle so it enters IF/ID.
  5. Otherwise: PC<=PC+4.
- Simultaneous events:
  - Redirect and HALT fetch in the same cycle: the redirect wins and HALT is discarded (wrong path).
  - Stall and HALT in the same cycle: the PC holds and the state stays RUN; HALT is re-evaluated next cycle.
- i_enable=0: PC and state hold, o_flush is forced to 0, and IF_inst/IF_next_pc still reflect the current PC.
- Latency: a redirect asserted in cycle N yields the target instruction on IF_inst in cycle N+1.

Decomposition:
- Shared package: HALT_OP=32'hFFFF_FFFF, NOP=32'h0, PC_INC=4, state encodings.
- One sub-module: if_instr_mem (combinational read, synchronous write).
- PC register, FSM and next-PC mux stay in if_fetch_unit.

Test Plan:
- Reset, then load 0x11,0x22,0x33 at words 0-2 in IDLE, then start. Required: IF_inst=0x11,0x22,0x33 on successive cycles; IF_next_pc=4,8,12.
- In RUN at PC=8, pulse i_branch_taken with target 0x40 (word 16 = 0xAB). Required: o_flush=1 that cycle; next cycle o_pc=0x40, IF_inst=0xAB.
- Same cycle: i_stall=1 and i_jump=1 (target 0x80). Required: PC holds, o_flush=0. Next cycle, stall=0 with jump still high: PC<=0x80, o_flush=1.
- HALT_OP at word 3. Required: IF_inst=0xFFFFFFFF once at PC=12; then o_halt=1, IF_inst=0, o_pc stays 12; i_load_we in HALTED leaves memory unchanged.
- HALT fetched while i_branch_taken=1 (target 0). Required: no halt, PC<=0, o_flush=1.
- Drop i_enable for 3 cycles mid-RUN, then assert i_rst=0 asynchronously between edges. Required: PC frozen while disabled; on reset, o_pc=0 and IF_inst=0 immediately, state IDLE.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   HALT_OP       : instruction word that stops fetch when it is accepted
//   NOP           : word presented on IF_inst when the stage is not running
//   PC_INC        : sequential PC step in bytes
//   fetch_state_t : fetch sequencer states (IDLE / RUN / HALTED)
package if_fetch_unit_pkg;

    localparam logic [31:0] HALT_OP = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] PC_INC  = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_instr_mem.sv
// Instruction memory for the fetch stage: combinational read, synchronous
// write. Contents are never reset, so a loaded program survives reset.
//   i_clk   : clock, rising edge
//   i_we    : write strobe (already qualified by the caller)
//   i_waddr : write word address
//   i_wdata : write word
//   i_raddr : read word address
//   o_rdata : word at i_raddr (combinational)
module if_instr_mem #(
    parameter int unsigned MSB       = 32,
    parameter int unsigned IMEM_ADDR = 8
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [IMEM_ADDR-1:0] i_waddr,
    input  logic [MSB-1:0]       i_wdata,
    input  logic [IMEM_ADDR-1:0] i_raddr,
    output logic [MSB-1:0]       o_rdata
);

    logic [MSB-1:0] mem [2**IMEM_ADDR];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, fetch sequencer and next-PC
// selection, feeding the IF/ID pipeline register.
//   i_clk, i_rst         : clock (rising edge), asynchronous active-low reset
//   i_enable             : run/step enable; low freezes PC and state
//   i_start              : IDLE -> RUN request
//   i_stall              : hold the PC (hazard stall)
//   i_branch_taken/target: taken-branch redirect from ID
//   i_jump/target        : jump redirect from ID
//   i_load_we/addr/data  : program load port, honoured only in IDLE
//   IF_next_pc, IF_inst  : PC+4 and fetched word (zero unless running)
//   o_flush              : redirect accepted this cycle
//   o_pc                 : current PC
//   o_halt               : high while halted
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned MSB       = 32,
    parameter int unsigned IMEM_ADDR = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    input  logic                 i_start,
    input  logic                 i_stall,
    input  logic                 i_branch_taken,
    input  logic [MSB-1:0]       i_branch_target,
    input  logic                 i_jump,
    input  logic [MSB-1:0]       i_jump_target,
    input  logic                 i_load_we,
    input  logic [IMEM_ADDR-1:0] i_load_addr,
    input  logic [MSB-1:0]       i_load_data,
    output logic [MSB-1:0]       IF_next_pc,
    output logic [MSB-1:0]       IF_inst,
    output logic                 o_flush,
    output logic [MSB-1:0]       o_pc,
    output logic                 o_halt
);

    fetch_state_t   state;
    logic [MSB-1:0] pc;
    logic [MSB-1:0] pc_next;
    logic [MSB-1:0] pc_inc;
    logic [MSB-1:0] imem_rdata;
    logic           imem_we;
    logic           in_run;
    logic           redirect;
    logic           halt_fetch;
    logic           take_halt;
    logic           halt_q;

    assign in_run     = (state == ST_RUN);
    assign imem_we    = i_load_we && (state == ST_IDLE);
    assign pc_inc     = pc + MSB'(PC_INC);
    assign redirect   = i_branch_taken || i_jump;
    assign halt_fetch = (imem_rdata == MSB'(HALT_OP));

    if_instr_mem #(
        .MSB       (MSB),
        .IMEM_ADDR (IMEM_ADDR)
    ) u_imem (
        .i_clk   (i_clk),
        .i_we    (imem_we),
        .i_waddr (i_load_addr),
        .i_wdata (i_load_data),
        .i_raddr (pc[IMEM_ADDR+1:2]),
        .o_rdata (imem_rdata)
    );

    // Next-PC priority: stall, branch, jump, halt, sequential.
    // A redirect beats a HALT fetched on the wrong path.
    always_comb begin
        pc_next   = pc;
        take_halt = 1'b0;
        if (in_run) begin
            if (i_stall) begin
                pc_next = pc;
            end else if (i_branch_taken) begin
                pc_next = i_branch_target;
            end else if (i_jump) begin
                pc_next = i_jump_target;
            end else if (halt_fetch) begin
                take_halt = 1'b1;
            end else begin
                pc_next = pc_inc;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state  <= ST_IDLE;
            pc     <= '0;
            halt_q <= 1'b0;
        end else if (i_enable) begin
            pc <= pc_next;
            unique case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (take_halt) begin
                        state  <= ST_HALTED;
                        halt_q <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state  <= ST_IDLE;
                    halt_q <= 1'b0;
                end
            endcase
        end
    end

    assign IF_inst    = in_run ? imem_rdata : MSB'(NOP);
    assign IF_next_pc = in_run ? pc_inc : '0;
    assign o_flush    = in_run && i_enable && !i_stall && redirect;
    assign o_pc       = pc;
    assign o_halt     = halt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        i_clk;
    logic        i_rst;
    logic        i_enable;
    logic        i_start;
    logic        i_stall;
    logic        i_branch_taken;
    logic [31:0] i_branch_target;
    logic        i_jump;
    logic [31:0] i_jump_target;
    logic        i_load_we;
    logic [7:0]  i_load_addr;
    logic [31:0] i_load_data;
    logic [31:0] IF_next_pc;
    logic [31:0] IF_inst;
    logic        o_flush;
    logic [31:0] o_pc;
    logic        o_halt;

    if_fetch_unit #(
        .MSB       (32),
        .IMEM_ADDR (8)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_enable        (i_enable),
        .i_start         (i_start),
        .i_stall         (i_stall),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_jump          (i_jump),
        .i_jump_target   (i_jump_target),
        .i_load_we       (i_load_we),
        .i_load_addr     (i_load_addr),
        .i_load_data     (i_load_data),
        .IF_next_pc      (IF_next_pc),
        .IF_inst         (IF_inst),
        .o_flush         (o_flush),
        .o_pc            (o_pc),
        .o_halt          (o_halt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rst, en, start, stall, br, jmp, we;
        logic [31:0] bt, jt, wd;
        logic [7:0]  wa;
    } stim_t;

    typedef struct {
        logic [31:0] inst, npc, pc;
        logic        flush, halt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model: mode 0 = idle, 1 = running, 2 = halted.
    int unsigned m_mode = 0;
    logic [31:0] m_pc   = '0;
    logic [31:0] m_mem [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: '0};
        s.rst = 1'b1;
        s.en  = 1'b1;
        return s;
    endfunction

    function automatic exp_t model_out(input stim_t s);
        exp_t e;
        bit   running;
        running = (m_mode == 1);
        e.pc    = m_pc;
        e.halt  = (m_mode == 2);
        e.inst  = running ? m_mem[m_pc[9:2]] : 32'h0;
        e.npc   = running ? m_pc + 32'd4 : 32'h0;
        e.flush = running && s.en && !s.stall && (s.br || s.jmp);
        return e;
    endfunction

    task automatic model_edge(input stim_t s);
        logic [31:0] word;
        word = m_mem[m_pc[9:2]];
        if (s.we && m_mode == 0) m_mem[s.wa] = s.wd;
        if (!s.rst) begin
            m_mode = 0;
            m_pc   = 0;
        end else if (s.en) begin
            if (m_mode == 0) begin
                if (s.start) m_mode = 1;
            end else if (m_mode == 1) begin
                if (s.stall)                 m_pc = m_pc;
                else if (s.br)              m_pc = s.bt;
                else if (s.jmp)             m_pc = s.jt;
                else if (word == 32'hFFFF_FFFF) m_mode = 2;
                else                         m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic drive(input stim_t s);
        i_rst           = s.rst;
        i_enable        = s.en;
        i_start         = s.start;
        i_stall         = s.stall;
        i_branch_taken  = s.br;
        i_branch_target = s.bt;
        i_jump          = s.jmp;
        i_jump_target   = s.jt;
        i_load_we       = s.we;
        i_load_addr     = s.wa;
        i_load_data     = s.wd;
    endtask

    // One clock cycle: apply inputs after the edge, record what the outputs
    // must show for this cycle, then advance the model over the next edge.
    task automatic cycle(input stim_t s);
        @(posedge i_clk);
        #1;
        drive(s);
        if (!s.rst) begin
            m_mode = 0;
            m_pc   = 0;
        end
        sb.push_back(model_out(s));
        model_edge(s);
    endtask

    // Reset asserted between clock edges; outputs must clear before the next edge.
    task automatic async_reset();
        stim_t s;
        @(posedge i_clk);
        #3;
        s = idle_stim();
        s.rst = 1'b0;
        drive(s);
        m_mode = 0;
        m_pc   = 0;
        sb.push_back(model_out(s));
    endtask

    // Monitor: every cycle the DUT presents its outputs at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_inst",  IF_inst,    e.inst);
                chk("sb_npc",   IF_next_pc, e.npc);
                chk("sb_pc",    o_pc,       e.pc);
                chk("sb_flush", {31'b0, o_flush}, {31'b0, e.flush});
                chk("sb_halt",  {31'b0, o_halt},  {31'b0, e.halt});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        logic [31:0] w;

        s = idle_stim();
        s.rst = 1'b0;
        drive(s);
        for (int i = 0; i < 256; i++) m_mem[i] = '0;

        cycle(s);
        cycle(s);
        #1;
        chk("reset_pc",   o_pc,    32'h0);
        chk("reset_inst", IF_inst, 32'h0);
        chk("reset_halt", {31'b0, o_halt},  32'h0);
        chk("reset_flush", {31'b0, o_flush}, 32'h0);

        // Program load in IDLE: every word defined, directed words on top.
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            if (w == 32'hFFFF_FFFF) w = 32'h1;
            case (i)
                0:  w = 32'h11;
                1:  w = 32'h22;
                2:  w = 32'h33;
                3:  w = 32'hFFFF_FFFF;
                16: w = 32'hAB;
                32: w = 32'hCD;
                default: ;
            endcase
            s = idle_stim();
            s.we = 1'b1;
            s.wa = 8'(i);
            s.wd = w;
            cycle(s);
        end

        s = idle_stim(); s.start = 1'b1; cycle(s);
        s = idle_stim(); cycle(s);
        #1; chk("w0_inst", IF_inst, 32'h11); chk("w0_npc", IF_next_pc, 32'd4);
        cycle(s);
        #1; chk("w1_inst", IF_inst, 32'h22); chk("w1_npc", IF_next_pc, 32'd8);
        s.br = 1'b1; s.bt = 32'h40; cycle(s);
        #1; chk("w2_inst", IF_inst, 32'h33); chk("w2_npc", IF_next_pc, 32'd12);
        chk("br_flush", {31'b0, o_flush}, 32'h1);
        s = idle_stim(); s.stall = 1'b1; s.jmp = 1'b1; s.jt = 32'h80; cycle(s);
        #1; chk("br_pc", o_pc, 32'h40); chk("br_inst", IF_inst, 32'hAB);
        chk("stall_flush", {31'b0, o_flush}, 32'h0);
        s.stall = 1'b0; cycle(s);
        #1; chk("stall_pc", o_pc, 32'h40); chk("jmp_flush", {31'b0, o_flush}, 32'h1);
        s = idle_stim(); s.jmp = 1'b1; s.jt = 32'd12; cycle(s);
        #1; chk("jmp_pc", o_pc, 32'h80); chk("jmp_inst", IF_inst, 32'hCD);
        s = idle_stim(); s.br = 1'b1; s.bt = 32'h0; cycle(s);
        #1; chk("wp_halt_inst", IF_inst, 32'hFFFF_FFFF); chk("wp_flush", {31'b0, o_flush}, 32'h1);
        s = idle_stim(); cycle(s);
        #1; chk("wp_pc", o_pc, 32'h0); chk("wp_nohalt", {31'b0, o_halt}, 32'h0);
        cycle(s); cycle(s); cycle(s);
        #1; chk("halt_fetch_pc", o_pc, 32'd12); chk("halt_fetch_inst", IF_inst, 32'hFFFF_FFFF);
        s.we = 1'b1; s.wa = 8'd3; s.wd = 32'h55; cycle(s);
        #1; chk("halted", {31'b0, o_halt}, 32'h1); chk("halted_inst", IF_inst, 32'h0);
        chk("halted_pc", o_pc, 32'd12); chk("halted_npc", IF_next_pc, 32'h0);
        s = idle_stim(); cycle(s);
        #1; chk("halted_hold_pc", o_pc, 32'd12);

        async_reset();
        #1; chk("areset_pc", o_pc, 32'h0); chk("areset_halt", {31'b0, o_halt}, 32'h0);
        s = idle_stim(); cycle(s);
        s.start = 1'b1; cycle(s);
        s = idle_stim(); cycle(s); cycle(s); cycle(s);
        s.br = 1'b1; s.bt = 32'h0; cycle(s);
        #1; chk("mem_kept_halt", IF_inst, 32'hFFFF_FFFF);
        s = idle_stim(); cycle(s); cycle(s);
        for (int i = 0; i < 3; i++) begin
            s = idle_stim(); s.en = 1'b0; s.br = 1'b1; s.bt = 32'h40;
            cycle(s);
            #1; chk("dis_pc", o_pc, 32'd8); chk("dis_inst", IF_inst, 32'h33);
            chk("dis_flush", {31'b0, o_flush}, 32'h0);
        end
        async_reset();
        #1; chk("mid_reset_pc", o_pc, 32'h0); chk("mid_reset_inst", IF_inst, 32'h0);

        // Randomized phase against the model.
        for (int it = 0; it < 20; it++) begin
            s = idle_stim(); cycle(s);
            for (int k = 0; k < 24; k++) begin
                s = idle_stim();
                s.we = 1'b1;
                s.wa = 8'($urandom_range(0, 255));
                s.wd = ($urandom_range(0, 11) == 0) ? 32'hFFFF_FFFF : $urandom;
                s.start = ($urandom_range(0, 23) == 0);
                cycle(s);
            end
            s = idle_stim(); s.start = 1'b1; cycle(s);
            for (int k = 0; k < 60; k++) begin
                s = idle_stim();
                s.en    = ($urandom_range(0, 7) != 0);
                s.stall = ($urandom_range(0, 5) == 0);
                s.br    = ($urandom_range(0, 9) == 0);
                s.jmp   = ($urandom_range(0, 9) == 0);
                s.bt    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h3FF);
                s.jt    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h3FF);
                s.we    = ($urandom_range(0, 7) == 0);
                s.wa    = 8'($urandom);
                s.wd    = $urandom;
                s.start = ($urandom_range(0, 1) == 0);
                cycle(s);
            end
            async_reset();
        end

        @(negedge i_clk);
        #1;
        chk("sb_drained", sb.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
